// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC/nPC pair driving a byte-addressed ROM and a registered
// IF/ID stage with valid/ready handshake, delayed-branch redirects with annul, and halt.
//
// state  | meaning
// S_IDLE | one cycle after reset, no fetch
// S_RUN  | fetching, advances when the IF/ID stage is free or being consumed
// S_HALT | fetch stopped until reset; a held instruction may still drain
module fetch_sequencer #(
  parameter int ADDR_WIDTH = 9,
  parameter int RESET_PC   = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [31:0]           rom_data,
  output logic [31:0]           instr_out,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  id_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic                  annul,
  input  logic                  halt,
  output logic                  misalign,
  output logic [CNT_WIDTH-1:0]  issue_count,
  output logic                  halted
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_RST = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] STEP   = ADDR_WIDTH'(4);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d, npc_q, npc_d;
  logic [31:0]             instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]   ipc_q, ipc_d;
  logic                    valid_q, valid_d;
  logic                    annul_pending_q, annul_pending_d;
  logic                    misalign_q, misalign_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    halted_q, halted_d;

  logic                    advance;
  logic                    annul_kill;
  logic [ADDR_WIDTH-1:0]   tgt;

  assign advance    = (state_q == S_RUN) && (!valid_q || id_ready);
  assign annul_kill = annul_pending_q || (redirect && annul);
  assign tgt        = {redirect_target[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    npc_d           = npc_q;
    instr_d         = instr_q;
    ipc_d           = ipc_q;
    valid_d         = valid_q;
    annul_pending_d = annul_pending_q;
    cnt_d           = cnt_q;
    misalign_d      = redirect && (redirect_target[1:0] != 2'b00);

    case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   if (halt) state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    if (advance) begin
      instr_d         = rom_data;
      ipc_d           = pc_q;
      valid_d         = !annul_kill;
      annul_pending_d = 1'b0;
      if (redirect) begin
        pc_d  = tgt;
        npc_d = tgt + STEP;
      end else begin
        pc_d  = npc_q;
        npc_d = npc_q + STEP;
      end
      if (!annul_kill && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end else if (state_q == S_RUN) begin
      // Stalled redirect: current PC is the delay slot, the branch lands via nPC.
      if (redirect) begin
        npc_d = tgt;
        if (annul) annul_pending_d = 1'b1;
      end
    end else if (id_ready) begin
      valid_d = 1'b0;
    end

    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      pc_q            <= PC_RST;
      npc_q           <= PC_RST + STEP;
      instr_q         <= '0;
      ipc_q           <= '0;
      valid_q         <= 1'b0;
      annul_pending_q <= 1'b0;
      misalign_q      <= 1'b0;
      cnt_q           <= '0;
      halted_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      npc_q           <= npc_d;
      instr_q         <= instr_d;
      ipc_q           <= ipc_d;
      valid_q         <= valid_d;
      annul_pending_q <= annul_pending_d;
      misalign_q      <= misalign_d;
      cnt_q           <= cnt_d;
      halted_q        <= halted_d;
    end
  end

  assign rom_addr    = {pc_q[ADDR_WIDTH-1:2], 2'b00};
  assign instr_out   = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign misalign    = misalign_q;
  assign issue_count = cnt_q;
  assign halted      = halted_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction fetch controller that sequences the byte-addressed instruction ROM (rom_512x8, 32-bit word assembled from 4 bytes at the addressed byte). It maintains the SPARC-style PC/nPC pair and drives the ROM address. It registers each fetched word into an IF/ID output stage with a valid/ready handshake. It accepts delayed-branch redirects with annul and a halt request from downstream.

Parameters:
ADDR_WIDTH, 9, ROM byte-address width (512 bytes); PC/nPC wrap modulo 2^ADDR_WIDTH
RESET_PC, 0, PC value loaded on reset; nPC loads RESET_PC+4
CNT_WIDTH, 16, width of the issued-instruction counter

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
rom_addr  out  ADDR_WIDTH  byte address to ROM; combinational copy of PC register
rom_data  in  32  ROM DataOut; combinational, valid same cycle as rom_addr
instr_out  out  32  registered instruction word to decode
instr_pc  out  ADDR_WIDTH  PC of instr_out
instr_valid  out  1  instr_out is a live instruction
id_ready  in  1  decode accepts instr_out this cycle
redirect  in  1  branch taken; one-cycle pulse
redirect_target  in  ADDR_WIDTH  branch target byte address
annul  in  1  qualifies redirect; squash the delay-slot instruction
halt  in  1  stop fetching; sticky until reset
misalign  out  1  one-cycle pulse: redirect_target[1:0] != 0
issue_count  out  CNT_WIDTH  number of valid instructions issued; saturates at all-ones
halted  out  1  high in HALT state

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset has priority over all inputs, including mid-stall and mid-redirect. On reset:
  - PC=RESET_PC, nPC=RESET_PC+4, state=IDLE.
  - instr_out=0, instr_pc=0, instr_valid=0, misalign=0, issue_count=0, halted=0.
  - annul_pending=0.
- States:
  - IDLE: exactly one cycle after reset deasserts, no fetch; goes to RUN.
  - RUN: fetching.
  - HALT: entered on the edge where halt=1 in RUN; exited only by reset.
- advance = (state==RUN) && (!instr_valid || id_ready).
- Advance cycle:
  - instr_out<=rom_data, instr_pc<=PC, instr_valid<=!annul_kill.
  - annul_kill = annul_pending || (redirect && annul).
  - PC<=nPC, nPC<=nPC+4, with wrap modulo 2^ADDR_WIDTH.
  - annul_pending<=0.
- Non-advance cycle with instr_valid && !id_ready: instr_out, instr_pc and instr_valid hold. PC/nPC hold unless redirect.
- Consumed without advance (id_ready=1, state!=RUN): instr_valid<=0.
- Redirect. T = redirect_target with bits[1:0] forced to 00; misalign<=1 if the original bits were nonzero, else 0. The instruction at the current PC is the delay slot.
  - With advance: PC<=T, nPC<=T+4.
  - Without advance: PC holds, nPC<=T. If annul=1, set annul_pending=1.
  - Redirect in IDLE/HALT: ignored except misalign.
- Annulled delay slot: consumes its fetch slot but is never presented valid and is not counted.
- issue_count increments on each advance with instr_valid<=1; holds at 2^CNT_WIDTH-1.
- halt and redirect in the same cycle: the advance and redirect of that cycle complete, then HALT. In HALT, a pending instr_valid still drains via id_ready.
- Latency: word at PC appears on instr_out one cycle after the advance edge. Sustained throughput is one instruction per cycle while id_ready=1.
- rom_addr low two bits are always 00.

Test Plan:
1. Reset, ROM preloaded with words W0..W3 at 0,4,8,12, id_ready=1 -> cycle after IDLE: instr_valid=1, instr_pc=0, instr_out=W0; then pc 4, 8, 12 on consecutive cycles; issue_count=4.
2. id_ready=0 for 3 cycles while instr_pc=4 -> instr_out/instr_pc held, rom_addr stays 8; on release pc 8 follows next cycle, no loss or duplication.
3. Redirect to 0x40 while PC=8, advancing -> issued sequence 4, 8, 0x40, 0x44. Same with annul=1 -> pc 8 never valid, issue_count excludes it.
4. Redirect target 0x41 during stall with annul=1 -> misalign pulses 1 cycle; PC=0x40 follows the stalled delay slot, which is dropped on release.
5. PC=0x1FC advancing -> next PC wraps to 0x000. halt asserted -> halted=1, no further advances, held instr drains on id_ready.
6. reset asserted mid-stall with instr_valid=1 -> next cycle all outputs at reset values; fetch resumes from RESET_PC after IDLE.
